// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg : shared single-precision FPU types, constants and helpers
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

   localparam int FP_W   = 32;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 27;   // {hidden, frac, guard, round, sticky}
   localparam int SUM_W  = 28;
   localparam int ZM_W   = 24;
   localparam int E_W    = 10;

   localparam logic [FP_W-1:0]       FP_NAN  = 32'hFFC00000;
   localparam logic signed [E_W-1:0] FP_BIAS = 10'sd127;
   localparam logic signed [E_W-1:0] FP_EMIN = -10'sd126;
   localparam logic signed [E_W-1:0] FP_EMAX = 10'sd127;

   typedef logic signed [E_W-1:0] fpu_exp_t;

   typedef enum logic [3:0] {
      GET_A_AND_B,
      UNPACK,
      SPECIAL_CASES,
      ALIGN,
      ADD_0,
      ADD_1,
      NORMALISE_1,
      NORMALISE_2,
      ROUND,
      PACK,
      PUT_Z
   } fpu_state_t;

   // Denormals share the minimum normal exponent; only the hidden bit differs.
   function automatic fpu_exp_t unbias(input logic [EXP_W-1:0] be);
      return (be == '0) ? FP_EMIN : ($signed({2'b00, be}) - FP_BIAS);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_adder_if.sv
// ---------------------------------------------------------------------------
// fpu_adder_if : STB/BUSY operand and result handshake of the FP adder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fpu_adder_if;
   import fpu_pkg::*;

   logic [FP_W-1:0] input_a;
   logic [FP_W-1:0] input_b;
   logic            adder_input_STB;
   logic            adder_BUSY;
   logic [FP_W-1:0] output_sum;
   logic            adder_output_STB;
   logic            output_module_BUSY;

   modport master (
      output input_a, input_b, adder_input_STB, output_module_BUSY,
      input  adder_BUSY, output_sum, adder_output_STB
   );

   modport slave (
      input  input_a, input_b, adder_input_STB, output_module_BUSY,
      output adder_BUSY, output_sum, adder_output_STB
   );

endinterface

`default_nettype wire

// File: rtl/fpu_align_shift.sv
// ---------------------------------------------------------------------------
// fpu_align_shift : 27-bit right shifter, shift clamped at 27, sticky to bit 0
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_align_shift
   import fpu_pkg::*;
(
   input  logic [MANT_W-1:0] i_mant,
   input  logic [E_W-1:0]    i_shamt,
   output logic [MANT_W-1:0] o_mant
);

   logic [MANT_W-1:0] w_shifted;
   logic [MANT_W-1:0] w_lost_mask;
   logic              w_sticky;

   always_comb begin
      w_shifted   = '0;
      w_lost_mask = '0;
      w_sticky    = 1'b0;
      o_mant      = '0;
      if (i_shamt >= E_W'(MANT_W)) begin
         o_mant = {{(MANT_W-1){1'b0}}, |i_mant};
      end else begin
         w_shifted   = i_mant >> i_shamt;
         w_lost_mask = ~({MANT_W{1'b1}} << i_shamt);
         w_sticky    = |(i_mant & w_lost_mask);
         o_mant      = {w_shifted[MANT_W-1:1], w_shifted[0] | w_sticky};
      end
   end

endmodule

`default_nettype wire

// File: rtl/fpu_adder.sv
// ---------------------------------------------------------------------------
// fpu_adder : multi-cycle IEEE-754 single adder, RNE rounding, denormals
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_adder
   import fpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   fpu_adder_if.slave bus
);

   fpu_state_t        r_state;
   logic [FP_W-1:0]   r_a, r_b, r_z, r_output_sum;
   logic [MANT_W-1:0] r_a_m, r_b_m;
   fpu_exp_t          r_a_e, r_b_e, r_z_e;
   logic              r_a_s, r_b_s, r_z_s;
   logic [SUM_W-1:0]  r_sum;
   logic [ZM_W-1:0]   r_z_m;
   logic              r_guard, r_round, r_sticky;
   logic              r_busy, r_output_stb;

   logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic              w_special;
   logic [FP_W-1:0]   w_special_z;
   logic              w_a_bigger;
   logic [E_W-1:0]    w_shamt;
   logic [MANT_W-1:0] w_align_in, w_align_out;
   logic [SUM_W-1:0]  w_sum;
   logic              w_sum_s;
   logic              w_round_up;
   logic [EXP_W-1:0]  w_pack_exp;

   assign bus.adder_BUSY       = r_busy;
   assign bus.output_sum       = r_output_sum;
   assign bus.adder_output_STB = r_output_stb;

   assign w_a_nan  = (&r_a[30:23]) &&  (|r_a[22:0]);
   assign w_b_nan  = (&r_b[30:23]) &&  (|r_b[22:0]);
   assign w_a_inf  = (&r_a[30:23]) && !(|r_a[22:0]);
   assign w_b_inf  = (&r_b[30:23]) && !(|r_b[22:0]);
   assign w_a_zero = (r_a[30:0] == '0);
   assign w_b_zero = (r_b[30:0] == '0);

   always_comb begin
      w_special   = 1'b1;
      w_special_z = '0;
      if (w_a_nan || w_b_nan) begin
         w_special_z = FP_NAN;
      end else if (w_a_inf) begin
         w_special_z = (w_b_inf && (r_a_s != r_b_s)) ? FP_NAN : r_a;
      end else if (w_b_inf) begin
         w_special_z = r_b;
      end else if (w_a_zero && w_b_zero) begin
         w_special_z = {r_a_s & r_b_s, 31'd0};
      end else if (w_a_zero) begin
         w_special_z = r_b;
      end else if (w_b_zero) begin
         w_special_z = r_a;
      end else begin
         w_special = 1'b0;
      end
   end

   // Only the smaller-exponent operand is shifted, so one shifter serves both.
   assign w_a_bigger = (r_a_e > r_b_e);
   assign w_shamt    = w_a_bigger ? E_W'(r_a_e - r_b_e) : E_W'(r_b_e - r_a_e);
   assign w_align_in = w_a_bigger ? r_b_m : r_a_m;

   fpu_align_shift u_align_shift (
      .i_mant  (w_align_in),
      .i_shamt (w_shamt),
      .o_mant  (w_align_out)
   );

   always_comb begin
      w_sum   = '0;
      w_sum_s = r_a_s;
      if (r_a_s == r_b_s) begin
         w_sum = {1'b0, r_a_m} + {1'b0, r_b_m};
      end else if (r_a_m >= r_b_m) begin
         w_sum = {1'b0, r_a_m} - {1'b0, r_b_m};
      end else begin
         w_sum   = {1'b0, r_b_m} - {1'b0, r_a_m};
         w_sum_s = r_b_s;
      end
   end

   assign w_round_up = r_guard && (r_round || r_sticky || r_z_m[0]);
   assign w_pack_exp = EXP_W'(r_z_e + FP_BIAS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= GET_A_AND_B;
         r_a          <= '0;
         r_b          <= '0;
         r_z          <= '0;
         r_output_sum <= '0;
         r_a_m        <= '0;
         r_b_m        <= '0;
         r_a_e        <= '0;
         r_b_e        <= '0;
         r_z_e        <= '0;
         r_a_s        <= 1'b0;
         r_b_s        <= 1'b0;
         r_z_s        <= 1'b0;
         r_sum        <= '0;
         r_z_m        <= '0;
         r_guard      <= 1'b0;
         r_round      <= 1'b0;
         r_sticky     <= 1'b0;
         r_busy       <= 1'b0;
         r_output_stb <= 1'b0;
      end else begin
         case (r_state)
            GET_A_AND_B: begin
               if (bus.adder_input_STB && !r_busy) begin
                  r_a     <= bus.input_a;
                  r_b     <= bus.input_b;
                  r_busy  <= 1'b1;
                  r_state <= UNPACK;
               end
            end
            UNPACK: begin
               r_a_m   <= {|r_a[30:23], r_a[22:0], 3'b000};
               r_b_m   <= {|r_b[30:23], r_b[22:0], 3'b000};
               r_a_e   <= unbias(r_a[30:23]);
               r_b_e   <= unbias(r_b[30:23]);
               r_a_s   <= r_a[31];
               r_b_s   <= r_b[31];
               r_state <= SPECIAL_CASES;
            end
            SPECIAL_CASES: begin
               if (w_special) begin
                  r_z     <= w_special_z;
                  r_state <= PUT_Z;
               end else begin
                  r_state <= ALIGN;
               end
            end
            ALIGN: begin
               if (w_a_bigger) begin
                  r_b_m <= w_align_out;
                  r_z_e <= r_a_e;
               end else begin
                  r_a_m <= w_align_out;
                  r_z_e <= r_b_e;
               end
               r_state <= ADD_0;
            end
            ADD_0: begin
               r_sum <= w_sum;
               r_z_s <= w_sum_s;
               if (w_sum == '0) begin
                  r_z     <= '0;
                  r_state <= PUT_Z;
               end else begin
                  r_state <= ADD_1;
               end
            end
            ADD_1: begin
               if (r_sum[27]) begin
                  r_z_m    <= r_sum[27:4];
                  r_guard  <= r_sum[3];
                  r_round  <= r_sum[2];
                  r_sticky <= |r_sum[1:0];
                  r_z_e    <= r_z_e + 10'sd1;
               end else begin
                  r_z_m    <= r_sum[26:3];
                  r_guard  <= r_sum[2];
                  r_round  <= r_sum[1];
                  r_sticky <= r_sum[0];
               end
               r_state <= NORMALISE_1;
            end
            NORMALISE_1: begin
               if (!r_z_m[23] && (r_z_e > FP_EMIN)) begin
                  r_z_m   <= {r_z_m[22:0], r_guard};
                  r_guard <= r_round;
                  r_round <= 1'b0;
                  r_z_e   <= r_z_e - 10'sd1;
               end else begin
                  r_state <= NORMALISE_2;
               end
            end
            NORMALISE_2: begin
               if (r_z_e < FP_EMIN) begin
                  r_z_m    <= {1'b0, r_z_m[23:1]};
                  r_z_e    <= r_z_e + 10'sd1;
                  r_sticky <= r_sticky | r_round;
                  r_round  <= r_guard;
                  r_guard  <= r_z_m[0];
               end else begin
                  r_state <= ROUND;
               end
            end
            ROUND: begin
               if (w_round_up) begin
                  r_z_m <= r_z_m + 24'd1;
                  if (&r_z_m) begin
                     r_z_e <= r_z_e + 10'sd1;
                  end
               end
               r_state <= PACK;
            end
            PACK: begin
               r_z[31] <= r_z_s;
               if (r_z_e > FP_EMAX) begin
                  r_z[30:0] <= {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               end else if ((r_z_e == FP_EMIN) && !r_z_m[23]) begin
                  r_z[30:0] <= {{EXP_W{1'b0}}, r_z_m[22:0]};
               end else begin
                  r_z[30:0] <= {w_pack_exp, r_z_m[22:0]};
               end
               r_state <= PUT_Z;
            end
            PUT_Z: begin
               r_output_sum <= r_z;
               r_output_stb <= 1'b1;
               if (r_output_stb && !bus.output_module_BUSY) begin
                  r_output_stb <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= GET_A_AND_B;
               end
            end
            default: r_state <= GET_A_AND_B;
         endcase
      end
   end

endmodule

`default_nettype wire
